// File: rtl/mmio_uart_tx_if.sv
// Core data-memory port slice seen by the memory-mapped UART transmitter.
interface mmio_uart_tx_if;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [2:0]  width;
  logic        read_enable;
  logic        write_enable;
  logic [31:0] read_data;
  logic        selected;

  modport master (
    output address, write_data, width, read_enable, write_enable,
    input  read_data, selected
  );

  modport slave (
    input  address, write_data, width, read_enable, write_enable,
    output read_data, selected
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS/DIVISOR registers,
// a small TX FIFO and a bit-serialiser with a programmable baud divisor.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDRESS    = 32'hFF00_0000,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd434
) (
  input  logic           clock,
  input  logic           reset,
  mmio_uart_tx_if.slave  bus,
  output logic           uart_tx,
  output logic           tx_busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           state;
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic [15:0]      divisor;
  logic [15:0]      bit_div;
  logic [15:0]      cyc_cnt;
  logic [7:0]       shift;
  logic [2:0]       bit_idx;

  logic       sel_c;
  logic [1:0] reg_sel_c;
  logic       full_c;
  logic       empty_c;
  logic       bit_done_c;
  logic       pop_c;
  logic       data_wr_c;
  logic       push_c;
  logic       ovf_event_c;
  logic       status_rd_c;
  logic       div_wr_c;

  // Bus fields that carry no information for this block.
  logic unused_bits;
  assign unused_bits = &{1'b0, bus.width, bus.write_data[31:16], bus.address[1:0]};

  // Address decode and access qualification
  assign sel_c       = (bus.address[31:4] == BASE_ADDRESS[31:4]);
  assign reg_sel_c   = bus.address[3:2];
  assign data_wr_c   = sel_c && bus.write_enable && (reg_sel_c == REG_DATA);
  assign div_wr_c    = sel_c && bus.write_enable && (reg_sel_c == REG_DIVISOR);
  assign status_rd_c = sel_c && bus.read_enable  && (reg_sel_c == REG_STATUS);

  assign full_c      = (count == CNT_W'(FIFO_DEPTH));
  assign empty_c     = (count == '0);
  assign bit_done_c  = (cyc_cnt == (bit_div - 16'd1));

  // The serialiser takes the head whenever it is idle and data is waiting,
  // so a store into a full FIFO still lands if a pop frees a slot that cycle.
  assign pop_c       = (state == S_IDLE) && !empty_c;
  assign push_c      = data_wr_c && (!full_c || pop_c);
  assign ovf_event_c = data_wr_c && full_c && !pop_c;

  assign tx_busy      = (state != S_IDLE) || !empty_c;
  assign bus.selected = sel_c;

  // Load data mux
  always_comb begin
    bus.read_data = '0;
    if (sel_c && bus.read_enable) begin
      case (reg_sel_c)
        REG_STATUS:  bus.read_data = {23'd0, 5'(count), overflow, tx_busy, empty_c, full_c};
        REG_DIVISOR: bus.read_data = {16'd0, divisor};
        default:     bus.read_data = '0;
      endcase
    end
  end

  // FIFO storage, no reset needed since count gates every read
  always_ff @(posedge clock) begin
    if (push_c) begin
      fifo_mem[wr_ptr] <= bus.write_data[7:0];
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Control registers; an overflow in the same cycle wins over a clearing read
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      divisor  <= DEFAULT_DIVISOR;
    end else begin
      if (ovf_event_c) begin
        overflow <= 1'b1;
      end else if (status_rd_c) begin
        overflow <= 1'b0;
      end
      if (div_wr_c) begin
        divisor <= (bus.write_data[15:0] == 16'd0) ? 16'd1 : bus.write_data[15:0];
      end
    end
  end

  // Serialiser FSM with registered line output
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      uart_tx <= 1'b1;
      bit_div <= DEFAULT_DIVISOR;
      cyc_cnt <= '0;
      shift   <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          uart_tx <= 1'b1;
          if (!empty_c) begin
            shift   <= fifo_mem[rd_ptr];
            bit_div <= divisor;
            cyc_cnt <= '0;
            bit_idx <= '0;
            uart_tx <= 1'b0;
            state   <= S_START;
          end
        end
        S_START: begin
          if (bit_done_c) begin
            cyc_cnt <= '0;
            bit_idx <= '0;
            uart_tx <= shift[0];
            state   <= S_DATA;
          end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (bit_done_c) begin
            cyc_cnt <= '0;
            shift   <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              uart_tx <= shift[1];
            end
          end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (bit_done_c) begin
            cyc_cnt <= '0;
            uart_tx <= 1'b1;
            state   <= S_IDLE;
          end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
          end
        end
        default: begin
          uart_tx <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed/randomised bench for mmio_uart_tx: frames are rebuilt from the
// 8N1 rules and compared slot by slot against a per-cycle log of uart_tx.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE     = 32'hFF00_0000;
  localparam logic [31:0] A_DATA   = BASE + 32'h0;
  localparam logic [31:0] A_STATUS = BASE + 32'h4;
  localparam logic [31:0] A_DIV    = BASE + 32'h8;
  localparam logic [31:0] A_RSVD   = BASE + 32'hC;
  localparam int          DEPTH    = 4;
  localparam int          LOG_N    = 16384;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic uart_tx;
  logic tx_busy;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .BASE_ADDRESS    (BASE),
    .FIFO_DEPTH      (DEPTH),
    .DEFAULT_DIVISOR (16'd434)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .uart_tx (uart_tx),
    .tx_busy (tx_busy)
  );

  always #5 clock = ~clock;

  // cyc = number of rising edges so far; logs hold values settled after edge cyc
  int   cyc = 0;
  logic tx_log   [LOG_N];
  logic busy_log [LOG_N];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (cyc < LOG_N) begin
      tx_log[cyc]   <= uart_tx;
      busy_log[cyc] <= tx_busy;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, output int edge_n);
    bus.address      = addr;
    bus.write_data   = data;
    bus.write_enable = 1'b1;
    @(posedge clock);
    #1;
    edge_n           = cyc;
    bus.write_enable = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    bus.address     = addr;
    bus.read_enable = 1'b1;
    #1;
    data = bus.read_data;
    @(posedge clock);
    #1;
    bus.read_enable = 1'b0;
  endtask

  function automatic logic [31:0] status_word(input logic full, input logic empty,
                                              input logic busy, input logic ovf, input int count);
    return {23'd0, count[4:0], ovf, busy, empty, full};
  endfunction

  // Frame popped at edge p with d cycles per bit: start, 8 data LSB first, stop
  task automatic check_frame(input string tag, input int p, input int d, input logic [7:0] b);
    check($sformatf("%s idle_before", tag), {31'd0, tx_log[p-1]}, 32'd1);
    for (int s = 0; s < 10; s++) begin
      logic exp_bit;
      logic obs;
      exp_bit = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : b[s-1];
      obs     = tx_log[p + s*d];
      for (int j = 1; j < d; j++) begin
        if (tx_log[p + s*d + j] !== obs) obs = 1'bx;
      end
      check($sformatf("%s slot%0d", tag, s), {31'd0, obs}, {31'd0, exp_bit});
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  b [6];
    int          s [6];
    int          e;
    int          p;
    int          n_acc;
    logic [15:0] rdiv;

    bus.address      = '0;
    bus.write_data   = '0;
    bus.width        = 3'd2;
    bus.read_enable  = 1'b0;
    bus.write_enable = 1'b0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    #2 reset = 1'b1;
    @(posedge clock);
    #1;
    bus_read(A_STATUS, rd);
    check("rst_status", rd, status_word(1'b0, 1'b1, 1'b0, 1'b0, 0));
    bus_read(A_DIV, rd);
    check("rst_divisor", rd, 32'd434);

    // Single 0xA5 frame at 4 cycles per bit; junk in the upper store bits
    bus_write(A_DIV, 32'd4, e);
    bus_write(A_DATA, {24'($urandom), 8'hA5}, s[0]);
    p = s[0] + 1;
    repeat (45) @(posedge clock);
    #1;
    check_frame("t1", p, 4, 8'hA5);
    check("t1_busy_stop", {31'd0, busy_log[p + 39]}, 32'd1);
    check("t1_busy_fall", {31'd0, busy_log[p + 40]}, 32'd0);

    // Five back-to-back stores at divisor 2: first byte leaves the FIFO at once
    bus_write(A_DIV, 32'd2, e);
    for (int k = 0; k < 5; k++) begin
      b[k] = 8'(k + 1);
      bus_write(A_DATA, {24'($urandom), b[k]}, s[k]);
    end
    n_acc = 5 - 1;
    bus_read(A_STATUS, rd);
    check("t2_status", rd, status_word(n_acc == DEPTH, 1'b0, 1'b1, 1'b0, n_acc));
    p = s[0] + 1;
    repeat (115) @(posedge clock);
    #1;
    for (int k = 0; k < 5; k++) begin
      check_frame($sformatf("t2_f%0d", k), p + k*21, 2, b[k]);
    end
    check("t2_busy_fall", {31'd0, busy_log[p + 4*21 + 20]}, 32'd0);

    // Slow frames so the FIFO fills: sixth byte must be dropped
    bus_write(A_DIV, 32'd100, e);
    for (int k = 0; k < 6; k++) begin
      b[k] = 8'($urandom);
      bus_write(A_DATA, {24'($urandom), b[k]}, s[k]);
    end
    p = s[0] + 1;
    bus_read(A_STATUS, rd);
    check("t3_status_ovf", rd, status_word(1'b1, 1'b0, 1'b1, 1'b1, DEPTH));
    bus_read(A_STATUS, rd);
    check("t3_status_clr", rd, status_word(1'b1, 1'b0, 1'b1, 1'b0, DEPTH));
    repeat (5010) @(posedge clock);
    #1;
    for (int k = 0; k < 5; k++) begin
      check_frame($sformatf("t3_f%0d", k), p + k*1001, 100, b[k]);
    end
    check("t3_busy_fall", {31'd0, busy_log[p + 4*1001 + 1000]}, 32'd0);
    check("t3_no_sixth", {31'd0, tx_log[p + 5*1001]}, 32'd1);

    // Divisor 0 is stored as 1
    bus_write(A_DIV, 32'd0, e);
    bus_read(A_DIV, rd);
    check("t4_div_read", rd, 32'd1);
    b[0] = 8'($urandom);
    bus_write(A_DATA, {24'd0, b[0]}, s[0]);
    p = s[0] + 1;
    repeat (15) @(posedge clock);
    #1;
    check_frame("t4", p, 1, b[0]);

    // Asynchronous reset during a zero data bit, with a second byte queued
    bus_write(A_DIV, 32'd8, e);
    b[0] = 8'($urandom) & 8'hF7;
    b[1] = 8'($urandom);
    bus_write(A_DATA, {24'd0, b[0]}, s[0]);
    bus_write(A_DATA, {24'd0, b[1]}, s[1]);
    p = s[0] + 1;
    repeat (34) @(posedge clock);
    #3;
    check("t5_pre_low", {31'd0, uart_tx}, 32'd0);
    reset = 1'b0;
    #1;
    check("t5_async_high", {31'd0, uart_tx}, 32'd1);
    check("t5_async_busy", {31'd0, tx_busy}, 32'd0);
    #2 reset = 1'b1;
    @(posedge clock);
    #1;
    bus_read(A_STATUS, rd);
    check("t5_status", rd, status_word(1'b0, 1'b1, 1'b0, 1'b0, 0));
    bus_read(A_DIV, rd);
    check("t5_divisor", rd, 32'd434);
    repeat (5) @(posedge clock);
    #1;
    check("t5_line_idle", {31'd0, uart_tx}, 32'd1);

    // Accesses outside the window, reserved/data reads, random divisor readback
    bus.address      = BASE + 32'h10;
    bus.write_data   = $urandom;
    bus.read_enable  = 1'b1;
    bus.write_enable = 1'b1;
    #1;
    check("t6_selected", {31'd0, bus.selected}, 32'd0);
    check("t6_read_data", bus.read_data, 32'd0);
    @(posedge clock);
    #1;
    bus.read_enable  = 1'b0;
    bus.write_enable = 1'b0;
    bus.address      = A_STATUS;
    #1;
    check("t6_selected_in", {31'd0, bus.selected}, 32'd1);
    bus_read(A_STATUS, rd);
    check("t6_status", rd, status_word(1'b0, 1'b1, 1'b0, 1'b0, 0));
    bus_read(A_DATA, rd);
    check("t6_data_read", rd, 32'd0);
    bus_write(A_RSVD, 32'h0000_0055, e);
    bus_read(A_RSVD, rd);
    check("t6_rsvd_read", rd, 32'd0);
    bus_read(A_DIV, rd);
    check("t6_div_after_rsvd", rd, 32'd434);
    rdiv = 16'($urandom_range(65535, 1));
    bus_write(A_DIV, {16'($urandom), rdiv}, e);
    bus_read(A_DIV, rd);
    check("t6_div_rand", rd, {16'd0, rdiv});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
